bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//   Parallel-in, serial-out word serializer with a valid/ready input handshake.
//   Sits directly upstream of the serial sequence detector and drives its 1-bit
//   input (x) one bit per clock. Upstream logic writes whole words; this block
//   emits them as a gap-free bit stream and holds a defined idle level between words.
// PARAMETERS
//   WIDTH      8   word width in bits; legal range >= 2
//   MSB_FIRST  1   1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//   IDLE_BIT   1   level driven on ser_out while no word is being shifted
// PORTS
//   clk        in   1      single clock; all logic on posedge
//   rst        in   1      reset, synchronous and active-high
//   in_data    in   WIDTH  parallel word; sampled only on an accepted handshake
//   in_valid   in   1      upstream presents in_data
//   in_ready   out  1      block can accept a word this cycle
//   ser_out    out  1      serial bit stream (feeds detector x)
//   ser_valid  out  1      ser_out carries a data bit this cycle
//   busy       out  1      a word is in flight (same as ser_valid)
//   word_done  out  1      one-cycle pulse coincident with the last bit of a word
// BEHAVIOUR
//   - One clock (clk). Reset is synchronous and active-high (rst).
//   - Reset: state=IDLE, cnt=0, shift reg=0, ser_out=IDLE_BIT, ser_valid=0,
//     busy=0, word_done=0. in_ready=0 while rst is high and 1 on the first cycle after.
//   - Accept: in_valid && in_ready at a posedge loads in_data into the shift
//     register and sets cnt=0. Without an accept, in_data is ignored.
//   - States:
//     - IDLE: in_ready=1. accept -> SHIFT; otherwise stay.
//     - SHIFT: in_ready=1 only when cnt==WIDTH-1 (last bit).
//       cnt<WIDTH-1 -> cnt+1, shift one position.
//       cnt==WIDTH-1 with accept -> reload, cnt=0, stay in SHIFT (back-to-back).
//       cnt==WIDTH-1 without accept -> IDLE.
//   - All outputs except in_ready are registered. in_ready is combinational
//     from state/cnt only and never from in_valid.
//   - Latency: a word accepted at edge N drives its first bit on ser_out during
//     the cycle after edge N. Bit k is driven during the cycle after edge N+k,
//     for k=0..WIDTH-1.
//   - Bit order: MSB_FIRST=1 sends in_data[WIDTH-1] down to [0].
//     MSB_FIRST=0 sends [0] up to [WIDTH-1].
//   - Back-to-back words produce a contiguous stream: ser_valid stays 1 with no
//     idle bit between words.
//   - word_done=1 exactly in the cycle that ser_out carries bit WIDTH-1 of a word.
//   - ser_out=IDLE_BIT whenever ser_valid=0.
//   - cnt is $clog2(WIDTH) bits wide and never exceeds WIDTH-1. It does not
//     wrap during a word.
//   - Reset mid-word: the word is aborted and its remaining bits are dropped.
//     Outputs take reset values on the next cycle. No word_done is issued.
//   - in_valid may be asserted while busy. It is held off (in_ready=0) until the
//     last-bit cycle. The word must remain stable until accepted.
// TESTING
//   1) rst=1 for 3 cycles, in_valid=1 -> in_ready=0, ser_out=1, ser_valid=0,
//      word_done=0, and no word is accepted.
//   2) MSB_FIRST=1, accept 8'b0110_0000 at edge N -> ser_out 0,1,1,0,0,0,0,0 on
//      cycles N+1..N+8. ser_valid=1 on those cycles. word_done=1 only on N+8.
//      ser_out=1 and ser_valid=0 from N+9.
//   3) Back-to-back 8'hA5 then 8'h3C with in_valid held -> 16 contiguous valid
//      bits 1010_0101_0011_1100. in_ready=1 only on the last-bit cycle.
//      Exactly two word_done pulses.
//   4) in_valid raised with 8'hFF at cycle 3 of word 8'h00 -> 8'hFF is not
//      accepted until the 8th bit of 8'h00. Its first 1 follows with no gap.
//   5) MSB_FIRST=0, accept 8'b0000_0110 -> ser_out 0,1,1,0,0,0,0,0.
//      The detector downstream asserts z on the 4th bit.
//   6) rst pulsed at bit 4 of 8'hF0 -> ser_out=1, ser_valid=0 on the next cycle.
//      No word_done is issued. A new accept afterwards serializes cleanly.

Source files
------------

// File: rtl/bit_serializer_if.sv
// Handshake and serial-stream bundle between the upstream word source and bit_serializer.
// The slave side is the serializer; the master side is whatever feeds it and consumes the stream.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             word_done;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ser_out,
        output ser_valid,
        output busy,
        output word_done
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  busy,
        input  word_done
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out word serializer with a valid/ready input handshake.
// Emits words as a gap-free bit stream and holds IDLE_BIT between words.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    bit_serializer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic             ser_out_r, ser_out_next;
    logic             ser_valid_r, ser_valid_next;
    logic             word_done_r, word_done_next;
    logic             last_bit;
    logic             ready;
    logic             accept;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Bit that becomes current after one shift of the held word.
    function automatic logic next_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-2] : w[1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);
    assign ready    = !rst && ((state == IDLE) || last_bit);
    assign accept   = bus.in_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            ser_out_r   <= IDLE_BIT;
            ser_valid_r <= 1'b0;
            word_done_r <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            shreg       <= shreg_next;
            ser_out_r   <= ser_out_next;
            ser_valid_r <= ser_valid_next;
            word_done_r <= word_done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last_bit && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // cnt always names the bit index currently on ser_out.
    always_comb begin
        cnt_next       = '0;
        shreg_next     = shreg;
        ser_out_next   = IDLE_BIT;
        ser_valid_next = 1'b0;
        word_done_next = 1'b0;
        if (accept) begin
            shreg_next     = bus.in_data;
            ser_out_next   = first_bit(bus.in_data);
            ser_valid_next = 1'b1;
        end else if (state == SHIFT && !last_bit) begin
            cnt_next       = cnt + CNT_W'(1);
            shreg_next     = shift_word(shreg);
            ser_out_next   = next_bit(shreg);
            ser_valid_next = 1'b1;
            word_done_next = (cnt == CNT_PENULT);
        end
    end

    assign bus.in_ready  = ready;
    assign bus.ser_out   = ser_out_r;
    assign bus.ser_valid = ser_valid_r;
    assign bus.busy      = ser_valid_r;
    assign bus.word_done = word_done_r;
endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first serializer share one stimulus stream
// and are compared bit by bit against per-word expected bit lists.
module tb_bit_serializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;

    int checks = 0;
    int errors = 0;
    int inflight = 0;
    bit started = 1'b0;
    bit [1:0] q_msb[$];
    bit [1:0] q_lsb[$];

    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(W)) bus_m ();
    bit_serializer_if #(.WIDTH(W)) bus_l ();

    assign bus_m.in_valid = in_valid;
    assign bus_m.in_data  = in_data;
    assign bus_l.in_valid = in_valid;
    assign bus_l.in_data  = in_data;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_m (
        .clk(clk), .rst(rst), .bus(bus_m.slave));
    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
        .clk(clk), .rst(rst), .bus(bus_l.slave));

    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    // Reference model: a word occupies W bit-slots; a new word may enter when at most
    // the current slot remains. Accepted words are expanded into ordered bit lists.
    always @(posedge clk) begin
        bit exp_ready;
        started = 1'b1;
        exp_ready = !rst && (inflight <= 1);
        chk("in_ready_msb", bus_m.in_ready, exp_ready);
        chk("in_ready_lsb", bus_l.in_ready, exp_ready);
        if (rst) begin
            inflight = 0;
            q_msb.delete();
            q_lsb.delete();
        end else begin
            if (inflight > 0) inflight--;
            if (in_valid && exp_ready) begin
                inflight += W;
                for (int i = W - 1; i >= 0; i--) q_msb.push_back({i == 0, in_data[i]});
                for (int i = 0; i < W; i++) q_lsb.push_back({i == W - 1, in_data[i]});
            end
        end
    end

    // Monitor: one slot per cycle, compared mid-cycle against the head of each list.
    always @(negedge clk) begin
        bit [1:0] e;
        bit exp_v;
        if (started) begin
            exp_v = (inflight > 0);
            chk("ser_valid_msb", bus_m.ser_valid, exp_v);
            chk("ser_valid_lsb", bus_l.ser_valid, exp_v);
            chk("busy_msb", bus_m.busy, exp_v);
            chk("busy_lsb", bus_l.busy, exp_v);
            if (exp_v) begin
                if (q_msb.size() == 0 || q_lsb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty at %0t: got 0 entries required 1", $time);
                end else begin
                    e = q_msb.pop_front();
                    chk("ser_out_msb", bus_m.ser_out, e[0]);
                    chk("word_done_msb", bus_m.word_done, e[1]);
                    e = q_lsb.pop_front();
                    chk("ser_out_lsb", bus_l.ser_out, e[0]);
                    chk("word_done_lsb", bus_l.word_done, e[1]);
                end
            end else begin
                chk("idle_out_msb", bus_m.ser_out, 1'b1);
                chk("idle_out_lsb", bus_l.ser_out, 1'b1);
                chk("idle_done_msb", bus_m.word_done, 1'b0);
                chk("idle_done_lsb", bus_l.word_done, 1'b0);
            end
        end
    end

    // Present a word and hold it until the handshake completes; in_valid stays high on return.
    task automatic send(input logic [W-1:0] w);
        bit done;
        done = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            @(posedge clk);
            if (bus_m.in_ready === 1'b1 && !rst) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: word %h got not accepted required accepted within 40 cycles", w);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset held with a word offered: nothing may be accepted.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        send(8'b0110_0000);           // single word, then drain
        idle(12);

        send(8'hA5);                  // back-to-back pair
        send(8'h3C);
        idle(12);

        send(8'h00);                  // FF raised mid-word, held off to last bit
        idle(2);
        send(8'hFF);
        idle(12);

        send(8'b0000_0110);
        idle(12);

        send(8'hF0);                  // reset mid-word, then a clean word
        idle(3);
        pulse_reset();
        idle(3);
        send(8'h96);
        idle(12);

        for (int i = 0; i < 40; i++) begin
            send(W'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                idle($urandom_range(0, 5));
                pulse_reset();
            end else if ($urandom_range(0, 2) == 0) begin
                idle($urandom_range(1, 12));
            end
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached required normal completion");
        $fatal(1, "watchdog");
    end
endmodule
